// File: rtl/mult_sequencer.sv
// Operand sequencer for a shift-add multiplier: buffers operand pairs in a FIFO,
// launches one multiply at a time, watches for completion and holds each product until popped.
module mult_sequencer #(
  parameter int DEPTH    = 4,
  parameter int WD_LIMIT = 15
) (
  input  logic        clck,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_go,
  input  logic        mul_done,
  input  logic [15:0] mul_prod,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_prod,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GO        = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem_a [DEPTH];
  logic [7:0]      r_mem_b [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_mul_a;
  logic [7:0]      r_mul_b;
  logic            r_mul_go;
  logic            r_res_valid;
  logic [15:0]     r_res_prod;
  logic            r_busy;
  logic            r_err;
  logic [WW-1:0]   r_wd;

  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      next_ptr = {AW{1'b0}};
    end else begin
      next_ptr = p + AW'(1);
    end
  endfunction

  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = in_valid && w_in_ready;
  // A new operation may only start once the previous result has been taken.
  assign w_pop      = (r_state == S_IDLE) && (r_count != {CW{1'b0}}) && !r_res_valid;

  // FIFO storage, written on every accepted push
  always_ff @(posedge clck) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencing FSM with watchdog and result holding register
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mul_a     <= 8'd0;
      r_mul_b     <= 8'd0;
      r_mul_go    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_prod  <= 16'd0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_wd        <= {WW{1'b0}};
    end else begin
      r_err    <= 1'b0;
      r_mul_go <= 1'b0;
      if (r_res_valid && res_ready) r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state  <= S_GO;
            r_mul_a  <= r_mem_a[r_rptr];
            r_mul_b  <= r_mem_b[r_rptr];
            r_mul_go <= 1'b1;
            r_busy   <= 1'b1;
            r_wd     <= {WW{1'b0}};
          end
        end
        S_GO: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_wd <= r_wd + WW'(1);
          if (!mul_done) begin
            r_state <= S_WAIT_DONE;
          end else if (r_wd >= WW'(1)) begin
            // Controller never acknowledged the go strobe: abandon the operation.
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          if (mul_done) begin
            r_res_prod  <= mul_prod;
            r_res_valid <= 1'b1;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end else if (r_wd >= WW'(WD_LIMIT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_go    = r_mul_go;
  assign res_valid = r_res_valid;
  assign res_prod  = r_res_prod;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: a behavioural multiplier controller plus a
// queue-based scoreboard of pushed pairs, launches and returned products.
module tb_mult_sequencer;

  logic        clck = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_go;
  logic        mul_done;
  logic [15:0] mul_prod;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_prod;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  // environment controls for the controller model
  int   ctl_dly = 10;
  logic ctl_stuck = 1'b0;
  logic m_done;
  int   m_cnt;
  logic [15:0] m_prod;

  // scoreboard state
  logic [15:0] pend [$];
  logic [15:0] res_log [$];
  logic        inflight = 1'b0;
  logic [15:0] exp_prod = 16'd0;
  logic        err_ok = 1'b0;
  logic        last_push = 1'b0;
  int ncyc = 0, go_cyc = 0, last_lat = 0, err_lat = 0, nres = 0, nerr = 0;

  mult_sequencer #(.DEPTH(4), .WD_LIMIT(15)) dut (
    .clck(clck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_go(mul_go),
    .mul_done(mul_done), .mul_prod(mul_prod), .res_valid(res_valid),
    .res_ready(res_ready), .res_prod(res_prod), .busy(busy), .err(err)
  );

  always #5 clck = ~clck;

  // Reference controller: drops done after seeing go, stays busy ctl_dly cycles.
  always @(posedge clck or posedge rst) begin
    if (rst) begin
      m_done <= 1'b1;
      m_cnt  <= 0;
      m_prod <= 16'd0;
    end else if (!ctl_stuck) begin
      if (m_done && mul_go) begin
        m_done <= 1'b0;
        m_cnt  <= ctl_dly;
        m_prod <= 16'(mul_a) * 16'(mul_b);
      end else if (!m_done) begin
        if (m_cnt <= 1) m_done <= 1'b1;
        else m_cnt <= m_cnt - 1;
      end
    end
  end
  assign mul_done = m_done;
  assign mul_prod = m_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with full scoreboard bookkeeping.
  task automatic cyc();
    logic pre_push, pre_pop, pre_rv, pre_go, pre_busy, pre_err;
    logic [7:0]  pa, pb, ia, ib, ea, eb;
    logic [15:0] pp, e;
    pre_push = in_valid && in_ready;
    pre_pop  = res_valid && res_ready;
    pre_rv = res_valid; pre_go = mul_go; pre_busy = busy; pre_err = err;
    pa = mul_a; pb = mul_b; pp = res_prod; ia = in_a; ib = in_b;
    @(posedge clck); #1;
    ncyc++;
    last_push = pre_push;
    if (mul_go) begin
      chk("go_fifo_nonempty", 32'(pend.size() != 0), 32'd1);
      chk("go_after_result_taken", 32'(pre_rv), 32'd0);
      chk("go_single_inflight", 32'(inflight), 32'd0);
      if (pend.size() != 0) begin
        e = pend.pop_front();
        ea = e[15:8]; eb = e[7:0];
        chk("mul_a_at_go", 32'(mul_a), 32'(ea));
        chk("mul_b_at_go", 32'(mul_b), 32'(eb));
        exp_prod = 16'(ea) * 16'(eb);
      end
      inflight = 1'b1;
      go_cyc = ncyc;
    end
    if (pre_push) pend.push_back({ia, ib});
    if (pre_go) chk("go_one_cycle", 32'(mul_go), 32'd0);
    if (pre_busy) begin
      chk("mul_a_stable", 32'(mul_a), 32'(pa));
      chk("mul_b_stable", 32'(mul_b), 32'(pb));
    end
    if (pre_rv && !pre_pop) begin
      chk("res_valid_held", 32'(res_valid), 32'd1);
      chk("res_prod_held", 32'(res_prod), 32'(pp));
    end
    if (pre_pop) chk("res_valid_cleared", 32'(res_valid), 32'd0);
    if (res_valid && !pre_rv) begin
      chk("result_has_op", 32'(inflight), 32'd1);
      chk("res_prod", 32'(res_prod), 32'(exp_prod));
      last_lat = ncyc - go_cyc;
      inflight = 1'b0;
      nres++;
      res_log.push_back(res_prod);
    end
    if (pre_err) chk("err_one_cycle", 32'(err), 32'd0);
    if (err) begin
      chk("err_expected", 32'(err_ok), 32'd1);
      chk("err_has_op", 32'(inflight), 32'd1);
      err_lat = ncyc - go_cyc;
      inflight = 1'b0;
      nerr++;
    end
    chk("in_ready", 32'(in_ready), 32'(pend.size() < 4));
    chk("busy", 32'(busy), 32'(inflight));
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (last_push) break;
    end
    chk("push_accepted", 32'(last_push), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n0;
    n0 = nres;
    for (int i = 0; i < budget && nres == n0; i++) cyc();
    chk("result_timeout", 32'(nres > n0), 32'd1);
  endtask

  task automatic wait_err(input int budget);
    int n0;
    n0 = nerr;
    for (int i = 0; i < budget && nerr == n0; i++) cyc();
    chk("err_timeout", 32'(nerr > n0), 32'd1);
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < budget && (pend.size() != 0 || inflight || res_valid); i++) cyc();
    chk("drained", 32'(pend.size() != 0 || inflight || res_valid), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mul_go"}, 32'(mul_go), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_prod"}, 32'(res_prod), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] exp5 [5];
    int n0, k;
    #2;
    chk_reset_values("reset");
    @(posedge clck); #1;
    rst = 1'b0;

    // single operation: product, latency and one-cycle result handshake
    push(8'd13, 8'd11);
    wait_res(40);
    chk("prod_13x11", 32'(res_log[$]), 32'h008F);
    chk("latency", 32'(last_lat), 32'd12);
    cyc();
    chk("res_valid_one_cycle", 32'(res_valid), 32'd0);

    push(8'd255, 8'd255);
    wait_res(40);
    chk("prod_255x255", 32'(res_log[$]), 32'hFE01);
    push(8'd0, 8'd200);
    wait_res(40);
    chk("prod_0x200", 32'(res_log[$]), 32'h0000);
    drain(50);

    // result held back: FIFO fills, no launch while a result is pending
    res_ready = 1'b0;
    push(8'd3, 8'd5);
    wait_res(40);
    n0 = nres;
    for (int i = 0; i < 4; i++) begin
      exp5[i] = 16'(8'(i + 7)) * 16'(8'(i * 9 + 2));
      push(8'(i + 7), 8'(i * 9 + 2));
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    exp5[4] = 16'd99 * 16'd201;
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd201;
    for (int i = 0; i < 20; i++) cyc();
    chk("fifth_blocked", 32'(pend.size()), 32'd4);
    chk("no_result_while_held", 32'(nres), 32'(n0));
    chk("held_prod", 32'(res_prod), 32'(16'd15));
    res_ready = 1'b1;
    for (int i = 0; i < 20 && !last_push; i++) cyc();
    chk("fifth_accepted", 32'(last_push), 32'd1);
    in_valid = 1'b0;
    drain(200);
    chk("five_results", 32'(nres - n0), 32'd5);
    k = res_log.size() - 5;
    for (int i = 0; i < 5; i++) chk("order", 32'(res_log[k + i]), 32'(exp5[i]));

    // controller ignores go: watchdog fires, next queued pair still launches
    ctl_stuck = 1'b1; err_ok = 1'b1;
    n0 = nres;
    push(8'd21, 8'd4);
    push(8'd6, 8'd7);
    wait_err(20);
    chk("err_wait_busy_lat", 32'(err_lat), 32'd3);
    wait_err(20);
    chk("err_second_lat", 32'(err_lat), 32'd3);
    chk("no_result_on_err", 32'(nres), 32'(n0));
    chk("stuck_fifo_empty", 32'(pend.size()), 32'd0);
    ctl_stuck = 1'b0;

    // controller never finishes: done-side watchdog limit
    ctl_dly = 40;
    push(8'd17, 8'd17);
    wait_err(40);
    chk("err_wait_done_lat", 32'(err_lat), 32'd16);
    err_ok = 1'b0;
    for (int i = 0; i < 60 && !mul_done; i++) cyc();
    chk("no_result_on_timeout", 32'(nres), 32'(n0));
    ctl_dly = 10;

    // reset in WAIT_DONE with two pairs queued
    res_ready = 1'b1;
    push(8'd40, 8'd3);
    push(8'd41, 8'd3);
    push(8'd42, 8'd3);
    for (int i = 0; i < 20 && !(busy && !mul_done); i++) cyc();
    cyc();
    chk("rst_in_flight", 32'(busy && !mul_done), 32'd1);
    chk("rst_queued", 32'(pend.size()), 32'd2);
    #2 rst = 1'b1;
    #1 chk_reset_values("midop_reset");
    pend.delete();
    inflight = 1'b0;
    @(posedge clck); #1;
    rst = 1'b0;
    n0 = nres;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (mul_go || res_valid) chk("post_reset_quiet", 32'({mul_go, res_valid}), 32'd0);
    end
    chk("post_reset_no_result", 32'(nres), 32'(n0));

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      ctl_dly   = $urandom_range(1, 12);
      cyc();
    end
    drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
